input_conditioner: RTL and testbench

Parametrised, multi-channel successor to the two-flop key debouncer. It conditions WIDTH asynchronous board inputs (keys, switches, GPIO sense lines) into the `clk` domain. Each channel has a configurable synchroniser depth, a per-channel stability counter that rejects glitches, optional per-bit inversion and single-cycle edge pulses. It sits between the board pins and consumers such as the core reset, the peripheral GPIO inputs and the user logic.

---
 rtl/input_conditioner.sv | 97 +++++++++
 tb/tb_input_conditioner.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// input_conditioner
//
// Multi-channel input conditioner that brings WIDTH asynchronous board inputs
// into the clk domain. Each channel has these stages:
//   optional inversion -> SYNC_STAGES-deep synchroniser -> stability filter
//   -> registered level `out` (plus rise/fall pulses).
// The filter flips `out[i]` only after STABLE_CYCLES consecutive synchronised
// samples that differ from it. A single sample that agrees with `out[i]`
// clears the partial count.
//
// Optional feature macro: INPUT_COND_EDGE_EN
//   defined   : rise/fall/any_change pulse registers are built.
//   undefined : rise/fall/any_change are tied to 0. Level timing is unchanged.

module input_conditioner #(
  parameter int               WIDTH         = 8,
  parameter int               SYNC_STAGES   = 2,
  parameter int               STABLE_CYCLES = 16,
  parameter logic [WIDTH-1:0] INVERT        = '0,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_change
);

  // Counter only needs to reach STABLE_CYCLES-1, so it never wraps.
  localparam int               CNT_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] x;     // post-inversion raw input
  logic [WIDTH-1:0] s;     // synchronised sample (last sync stage)
  logic [WIDTH-1:0] flip;  // out[i] takes the value s[i] on this edge

  assign x = in ^ INVERT;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;

    if (SYNC_STAGES == 1) begin : g_sync1
      // Single-flop synchroniser.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= RESET_VALUE[i];
        else       sync_q <= x[i];
      end
    end else begin : g_syncn
      // Shift chain: new sample enters at bit 0, and s is taken from the top bit.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= {SYNC_STAGES{RESET_VALUE[i]}};
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], x[i]};
      end
    end

    assign s[i]    = sync_q[SYNC_STAGES-1];
    assign flip[i] = (s[i] != out[i]) && (cnt_q == CNT_MAX);

    // Stability counter. It counts consecutive disagreeing samples and clears
    // on agreement or on a flip.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)                       cnt_q <= '0;
      else if ((s[i] == out[i]) || flip[i]) cnt_q <= '0;
      else                             cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Debounced level. The flipped bits are exactly those that reached the threshold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) out <= RESET_VALUE;
    else       out <= out ^ flip;
  end

`ifdef INPUT_COND_EDGE_EN
  // Edge pulses are registered alongside out. They are high during the first
  // cycle of the new level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise       <= '0;
      fall       <= '0;
      any_change <= 1'b0;
    end else begin
      rise       <= flip & ~out;
      fall       <= flip &  out;
      any_change <= |flip;
    end
  end
`else
  assign rise       = '0;
  assign fall       = '0;
  assign any_change = 1'b0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner.
// dut1 uses the default inversion and reset value and is checked every cycle
// against a sample-history reference model. dut2 uses INVERT=RESET_VALUE=4'b0011.
module tb_input_conditioner;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int SC = 8;
`ifdef INPUT_COND_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset1, reset2;
  logic [W-1:0] in1, in2;
  logic [W-1:0] out1, rise1, fall1, out2, rise2, fall2;
  logic         any1, any2;

  input_conditioner #(.WIDTH(W), .SYNC_STAGES(SS), .STABLE_CYCLES(SC),
                      .INVERT(4'b0000), .RESET_VALUE(4'b0000)) dut1 (
    .clk(clk), .reset(reset1), .in(in1), .out(out1),
    .rise(rise1), .fall(fall1), .any_change(any1));

  input_conditioner #(.WIDTH(W), .SYNC_STAGES(SS), .STABLE_CYCLES(SC),
                      .INVERT(4'b0011), .RESET_VALUE(4'b0011)) dut2 (
    .clk(clk), .reset(reset2), .in(in2), .out(out2),
    .rise(rise2), .fall(fall2), .any_change(any2));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model for dut1. A delay line of the last SS input samples gives
  // the synchronised value seen at each edge. The level flips after SC
  // consecutive samples that differ from it.
  logic [W-1:0] cur_in;
  logic [W-1:0] dq[$];
  logic [W-1:0] mout;
  int           run[W];
  logic [W-1:0] exp_rise, exp_fall;
  logic         exp_any;

  task automatic model_reset();
    dq.delete();
    for (int k = 0; k < SS; k++) dq.push_back(4'b0000);
    mout = 4'b0000;
    for (int k = 0; k < W; k++) run[k] = 0;
    exp_rise = '0; exp_fall = '0; exp_any = 1'b0;
  endtask

  // Drives cur_in into dut1, advances one clock and the model, then settles 1ns.
  task automatic tick();
    logic [W-1:0] s;
    in1 = cur_in;
    @(posedge clk);
    s = dq.pop_front();
    dq.push_back(cur_in);
    exp_rise = '0; exp_fall = '0;
    for (int k = 0; k < W; k++) begin
      if (s[k] != mout[k]) begin
        run[k]++;
        if (run[k] == SC) begin
          mout[k] = s[k];
          run[k]  = 0;
          if (EDGE) begin
            if (s[k]) exp_rise[k] = 1'b1;
            else      exp_fall[k] = 1'b1;
          end
        end
      end else begin
        run[k] = 0;
      end
    end
    exp_any = |(exp_rise | exp_fall);
    #1;
  endtask

  task automatic test_reset();
    reset1 = 1'b1; reset2 = 1'b1; in1 = '0; in2 = '0; cur_in = '0;
    model_reset();
    #2;
    n_cmp++;
    if ({out1, rise1, fall1, any1} !== 13'b0) begin
      n_bad++; $display("FAIL reset_dut1: got out=%b rise=%b fall=%b any=%b want all 0", out1, rise1, fall1, any1);
    end
    n_cmp++;
    if ({out2, rise2, fall2, any2} !== {4'b0011, 9'b0}) begin
      n_bad++; $display("FAIL reset_dut2: got out=%b rise=%b fall=%b any=%b want out=0011 rest 0", out2, rise2, fall2, any2);
    end
    @(posedge clk); #1;
    reset1 = 1'b0; reset2 = 1'b0;
  endtask

  task automatic test_clean_step();
    repeat (12) tick();
    cur_in[0] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      n_cmp++;
      if ({out1, rise1, fall1, any1} !== {mout, exp_rise, exp_fall, exp_any}) begin
        n_bad++; $display("FAIL clean_model e=%0d: got %b/%b/%b/%b want %b/%b/%b/%b", e, out1, rise1, fall1, any1, mout, exp_rise, exp_fall, exp_any);
      end
      n_cmp++;
      if ({out1, rise1} !== {3'b000, (e >= 10), 3'b000, (EDGE && e == 10)}) begin
        n_bad++; $display("FAIL clean_edge10 e=%0d: got out=%b rise=%b want out0=%0d rise0=%0d", e, out1, rise1, e >= 10, EDGE && e == 10);
      end
    end
  endtask

  task automatic test_glitch();
    int nr, nf, seen_hi;
    nr = 0; nf = 0; seen_hi = 0;
    cur_in[1] = 1'b1;
    repeat (7) begin
      tick();
      n_cmp++;
      if (out1[1] !== 1'b0 || rise1[1] !== 1'b0) begin
        n_bad++; $display("FAIL glitch7: got out1=%b rise1=%b want 0/0", out1[1], rise1[1]);
      end
    end
    cur_in[1] = 1'b0;
    repeat (12) begin
      tick();
      n_cmp++;
      if (out1[1] !== 1'b0 || rise1[1] !== 1'b0 || fall1[1] !== 1'b0) begin
        n_bad++; $display("FAIL glitch7_tail: got out1=%b rise1=%b fall1=%b want 0", out1[1], rise1[1], fall1[1]);
      end
    end
    cur_in[1] = 1'b1;
    for (int e = 0; e < 20; e++) begin
      if (e == 8) cur_in[1] = 1'b0;
      tick();
      n_cmp++;
      if ({out1, rise1, fall1, any1} !== {mout, exp_rise, exp_fall, exp_any}) begin
        n_bad++; $display("FAIL glitch8_model e=%0d: got %b/%b/%b/%b want %b/%b/%b/%b", e, out1, rise1, fall1, any1, mout, exp_rise, exp_fall, exp_any);
      end
      nr += int'(rise1[1]); nf += int'(fall1[1]); seen_hi += int'(out1[1]);
    end
    n_cmp++;
    if (nr != int'(EDGE) || nf != int'(EDGE)) begin
      n_bad++; $display("FAIL glitch8_pulses: got rise=%0d fall=%0d want %0d each", nr, nf, EDGE);
    end
    n_cmp++;
    if (seen_hi != SC || out1[1] !== 1'b0) begin
      n_bad++; $display("FAIL glitch8_level: got high_cycles=%0d final=%b want %0d and 0", seen_hi, out1[1], SC);
    end
  endtask

  task automatic test_bounce();
    int nr, nchg, out_edge;
    nr = 0; nchg = 0; out_edge = -1;
    for (int k = 0; k < 10; k++) begin
      cur_in[2] = (k % 2 == 0);
      repeat (3) begin
        tick();
        nchg += int'(out1[2]);
        n_cmp++;
        if ({out1, rise1, fall1, any1} !== {mout, exp_rise, exp_fall, exp_any}) begin
          n_bad++; $display("FAIL bounce_model: got %b/%b/%b/%b want %b/%b/%b/%b", out1, rise1, fall1, any1, mout, exp_rise, exp_fall, exp_any);
        end
      end
    end
    cur_in[2] = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      nr += int'(rise1[2]);
      if (out_edge < 0 && out1[2] === 1'b1) out_edge = e;
    end
    n_cmp++;
    if (nchg != 0 || out_edge != 10 || nr != int'(EDGE)) begin
      n_bad++; $display("FAIL bounce: got bounce_hi=%0d out_edge=%0d rises=%0d want 0/10/%0d", nchg, out_edge, nr, EDGE);
    end
  endtask

  task automatic test_invert();
    int fall_edge;
    fall_edge = -1;
    reset2 = 1'b1; in2 = 4'b0000;
    #2;
    reset2 = 1'b0;
    repeat (20) begin
      tick();
      n_cmp++;
      if ({out2, rise2, fall2, any2} !== {4'b0011, 9'b0}) begin
        n_bad++; $display("FAIL invert_idle: got out=%b rise=%b fall=%b any=%b want 0011/0", out2, rise2, fall2, any2);
      end
    end
    in2 = 4'b0001;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (fall_edge < 0 && fall2[0] === 1'b1) fall_edge = e;
      n_cmp++;
      if (out2 !== {3'b001, (e < 10)} || rise2 !== 4'b0000 || fall2 !== {3'b000, (EDGE && e == 10)}) begin
        n_bad++; $display("FAIL invert_press e=%0d: got out=%b rise=%b fall=%b", e, out2, rise2, fall2);
      end
    end
    n_cmp++;
    if (fall_edge != (EDGE ? 10 : -1)) begin
      n_bad++; $display("FAIL invert_fall_edge: got %0d want %0d", fall_edge, EDGE ? 10 : -1);
    end
  endtask

  task automatic test_reset_midcount();
    int out_edge;
    out_edge = -1;
    cur_in = 4'b0000;
    repeat (12) tick();
    cur_in[3] = 1'b1;
    repeat (SS + 5) tick();  // channel 3 now holds 5 differing samples
    reset1 = 1'b1;
    #1;
    n_cmp++;
    if ({out1, rise1, fall1, any1} !== 13'b0) begin
      n_bad++; $display("FAIL midcount_async: got out=%b rise=%b fall=%b any=%b want 0", out1, rise1, fall1, any1);
    end
    model_reset();
    @(posedge clk); #1;
    reset1 = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (out_edge < 0 && out1[3] === 1'b1) out_edge = e;
      n_cmp++;
      if ({out1, rise1, fall1, any1} !== {mout, exp_rise, exp_fall, exp_any}) begin
        n_bad++; $display("FAIL midcount_model e=%0d: got %b/%b/%b/%b want %b/%b/%b/%b", e, out1, rise1, fall1, any1, mout, exp_rise, exp_fall, exp_any);
      end
    end
    n_cmp++;
    if (out_edge != 10) begin
      n_bad++; $display("FAIL midcount_latency: got %0d want 10", out_edge);
    end
  endtask

  task automatic test_random();
    int hold[W];
    for (int k = 0; k < W; k++) hold[k] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < W; k++) begin
        if (hold[k] == 0) begin
          cur_in[k] = ~cur_in[k];
          hold[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 16) : $urandom_range(1, 9);
        end
        hold[k]--;
      end
      tick();
      n_cmp++;
      if ({out1, rise1, fall1, any1} !== {mout, exp_rise, exp_fall, exp_any}) begin
        n_bad++; $display("FAIL random c=%0d: got %b/%b/%b/%b want %b/%b/%b/%b", c, out1, rise1, fall1, any1, mout, exp_rise, exp_fall, exp_any);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_glitch();
    test_bounce();
    test_invert();
    test_reset_midcount();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
